sccb_cfg_sequencer: RTL and testbench
=====================================

// Module: sccb_cfg_sequencer
// PURPOSE
//  Sequences OV7670 register initialisation over SCCB (3-phase write) from an external register table.
//  Sits beside camera_capture in the PL. An AXI-lite control bit pulses start, and busy/done/count read back as status.
//  Each table entry is {reg_addr[7:0], reg_data[7:0]}. The sequencer walks the table until it reads the end marker.
// PARAMETERS
//  CLK_FREQ_HZ   100_000_000  ACLK frequency
//  SCCB_FREQ_HZ  100_000      SIOC frequency; QDIV = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), which is 250 at the defaults
//  DEV_ID        8'h42        SCCB write ID byte
//  TBL_AW        8            table address width; depth = 2**TBL_AW
//  GAP_Q         4            idle quarter-periods between transactions, SIOC and SIOD both high
// PORTS
//  ACLK       in   1        clock
//  ARESET     in   1        synchronous reset, active-high
//  start      in   1        1-cycle pulse; begin sequence from table entry 0
//  busy       out  1        high from the cycle after an accepted start until done asserts
//  done       out  1        sticky; set at sequence end, cleared by the next accepted start
//  wr_count   out  TBL_AW+1 number of register writes completed in the current/last sequence
//  tbl_addr   out  TBL_AW   table read address
//  tbl_data   in   16       table entry; synchronous ROM, valid 1 cycle after tbl_addr changes
//  sioc       out  1        SCCB clock
//  siod_o     out  1        SCCB data out
//  siod_oe    out  1        SCCB data drive enable; 0 = released (pull-up)
// BEHAVIOUR
//  Reset values: busy=0, done=0, wr_count=0, tbl_addr=0, sioc=1, siod_o=1, siod_oe=0, state=IDLE, qcnt=0.
//  Quarter tick: qcnt counts 0..QDIV-1 and is free-running only while busy. All SCCB edges occur on a tick.
//  States:
//   IDLE: on start -> FETCH (tbl_addr=0, wr_count=0, done=0, busy=1).
//   FETCH: 1 wait cycle for ROM latency -> DECODE.
//   DECODE: tbl_data==16'hFFFF -> DONE. tbl_data[15:8]==8'hF0 -> DELAY (macro only). Else latch entry -> START.
//   START: siod_oe=1. Q0: SIOC=1, SIOD=1. Q1: SIOD=0. Q2: SIOC=0. -> BYTE, byte index 0.
//   BYTE: sends DEV_ID, then reg_addr, then reg_data. Each byte is 8 bits MSB first plus a 9th don't-care bit.
//    Per bit: Q0 set SIOD (SIOC low), Q1 SIOC=1, Q3 SIOC=0. siod_oe=0 during the 9th bit. ACK is ignored (SCCB).
//   STOP: Q0 SIOD=0, Q1 SIOC=1, Q2 SIOD=1, Q3 siod_oe=0. Then wr_count++ -> GAP.
//   GAP: wait GAP_Q quarter ticks. If tbl_addr==2**TBL_AW-1 -> DONE (no wrap). Else tbl_addr++ -> FETCH.
//   DONE: busy=0, done=1 (same cycle) -> IDLE.
//  One entry = 3 + 27*4 + 4 quarters + GAP_Q = 119 quarters, i.e. 29,750 ACLK cycles at the defaults.
//  Start while busy is ignored. Start in the same cycle DONE is entered is ignored; it must be reissued from IDLE.
//  End marker at entry 0: done asserts 2 cycles after the start-accept cycle, wr_count=0, and no SIOC edge occurs.
//  Reset mid-transaction: next edge returns all outputs to reset values and releases the bus.
//   The camera may see a truncated transfer, which is recovered by the START of the next sequence.
//  wr_count saturates at 2**TBL_AW, which cannot be exceeded because the table does not wrap.
// CONFIGURATION
//  SCCB_DELAY_CMD_EN defined:
//   Entry 16'hF0NN (NN!=0) -> DELAY: wait NN*1 ms (NN*CLK_FREQ_HZ/1000 cycles), bus idle, wr_count unchanged.
//   Then -> GAP-free advance: tbl_addr++ -> FETCH, with the same last-entry rule as GAP.
//   Entry F000 is a 0 ms no-op advance. Required after COM7 reset writes (0x12<=0x80).
//  SCCB_DELAY_CMD_EN undefined: F0NN is treated as an ordinary write to register 0xF0 with data NN.
// TESTING
//  Default parameters except QDIV forced to 4 via CLK_FREQ_HZ=1_600_000. The bench models the ROM with 1-cycle latency.
//  Table {1280,1100,FFFF}, start -> 2 transactions on SCCB, decoded by the bench monitor:
//   ID 42/reg 12/data 80, then ID 42/reg 11/data 00. wr_count=2, done=1, busy=0.
//  Table {FFFF}, start -> done 2 cycles after the start-accept cycle, wr_count=0, sioc stays 1 throughout.
//  Start pulsed again mid-transaction -> ignored: transaction bytes unchanged, and tbl_addr restarts only after done.
//  ARESET asserted during the reg_addr byte -> next cycle sioc=1, siod_oe=0, busy=0, done=0.
//   A subsequent start completes the full table.
//  Table {F002,1100,FFFF} with SCCB_DELAY_CMD_EN -> 3,200 idle cycles (2 ms at 1.6 MHz), then one write, wr_count=1.
//   Without the macro -> writes reg F0 data 02, then reg 11, wr_count=2.
//  TBL_AW=2, table without a marker {0101,0202,0303,0404} -> 4 writes, done after entry 3, tbl_addr does not wrap to 0.

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
// sccb_cfg_sequencer
//   Walks an external register table and writes each {reg_addr, reg_data}
//   entry to an OV7670 over SCCB as a 3-phase write (ID, address, data).
//   The walk stops at the end marker 16'hFFFF or after the last table entry.
//   Optional feature macro: SCCB_DELAY_CMD_EN. When it is defined, entry
//   16'hF0NN waits NN milliseconds instead of writing.
//
// Ports
//   ACLK, ARESET  clock, synchronous active-high reset
//   start         1-cycle pulse, accepted only in IDLE
//   busy          high from the cycle after an accepted start until done
//   done          sticky end-of-sequence flag, cleared by the next accepted start
//   wr_count      register writes completed in the current/last sequence
//   tbl_addr      table read address (synchronous ROM, 1-cycle latency)
//   tbl_data      table entry {reg_addr[7:0], reg_data[7:0]}
//   sioc          SCCB clock
//   siod_o        SCCB data out
//   siod_oe       SCCB data drive enable (0 = released)
//   state_dbg     current FSM state, for observation only
//
// Handshake: start has no ready. A start pulse is taken only when the FSM is
// in IDLE. A pulse in any other state, including the one-cycle DONE state, is
// dropped.
module sccb_cfg_sequencer #(
  parameter int          CLK_FREQ_HZ  = 100_000_000,
  parameter int          SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int          TBL_AW       = 8,
  parameter int          GAP_Q        = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [TBL_AW:0]   wr_count,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [15:0]       tbl_data,
  output logic              sioc,
  output logic              siod_o,
  output logic              siod_oe,
  output logic [3:0]        state_dbg
);

  localparam int QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0]     QMAX      = QW'(QDIV - 1);
  localparam logic [QW-1:0]     Q_ONE     = QW'(1);
  localparam logic [TBL_AW-1:0] LAST_ADDR = '1;
  localparam logic [TBL_AW-1:0] ADDR_ONE  = TBL_AW'(1);
  localparam logic [TBL_AW:0]   WR_MAX    = {1'b1, {TBL_AW{1'b0}}};
  localparam logic [TBL_AW:0]   WR_ONE    = (TBL_AW+1)'(1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_Q - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_START  = 4'd3;
  localparam logic [3:0] S_BYTE   = 4'd4;
  localparam logic [3:0] S_STOP   = 4'd5;
  localparam logic [3:0] S_GAP    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_DELAY  = 4'd8;

  logic [3:0]    state;
  logic [QW-1:0] qcnt;      // free-running quarter divider, only while busy
  logic [7:0]    qph;       // quarter index inside START/BYTE/STOP/GAP
  logic [3:0]    bit_i;     // 0..7 data bits, 8 = don't-care (ACK) bit
  logic [1:0]    byte_i;    // 0 = DEV_ID, 1 = reg_addr, 2 = reg_data
  logic [7:0]    reg_addr_q;
  logic [7:0]    reg_data_q;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_sel;
  logic          tick;

`ifdef SCCB_DELAY_CMD_EN
  localparam logic [31:0] MS_CYC = 32'(CLK_FREQ_HZ / 1000);
  logic [31:0] dly_cnt;
`endif

  assign state_dbg = state;
  assign tick      = busy && (qcnt == QMAX);
  assign bit_sel   = 3'd7 - bit_i[2:0];

  always_comb begin
    cur_byte = DEV_ID;
    case (byte_i)
      2'd1:    cur_byte = reg_addr_q;
      2'd2:    cur_byte = reg_data_q;
      default: cur_byte = DEV_ID;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      qcnt       <= '0;
      qph        <= '0;
      bit_i      <= '0;
      byte_i     <= '0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_count   <= '0;
      tbl_addr   <= '0;
      sioc       <= 1'b1;
      siod_o     <= 1'b1;
      siod_oe    <= 1'b0;
`ifdef SCCB_DELAY_CMD_EN
      dly_cnt    <= '0;
`endif
    end else begin
      if (busy) qcnt <= (qcnt == QMAX) ? '0 : qcnt + Q_ONE;
      else      qcnt <= '0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            tbl_addr <= '0;
            wr_count <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
          end
        end

        // One cycle for the ROM to present the entry at tbl_addr.
        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          qph    <= '0;
          bit_i  <= '0;
          byte_i <= '0;
          if (tbl_data == 16'hFFFF) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef SCCB_DELAY_CMD_EN
          else if (tbl_data[15:8] == 8'hF0) begin
            state   <= S_DELAY;
            dly_cnt <= 32'(tbl_data[7:0]) * MS_CYC;
          end
`endif
          else begin
            reg_addr_q <= tbl_data[15:8];
            reg_data_q <= tbl_data[7:0];
            state      <= S_START;
          end
        end

        // Start condition: SIOD falls while SIOC is high.
        S_START: begin
          if (tick) begin
            qph <= qph + 8'd1;
            case (qph[1:0])
              2'd0: begin
                sioc    <= 1'b1;
                siod_o  <= 1'b1;
                siod_oe <= 1'b1;
              end
              2'd1:    siod_o <= 1'b0;
              default: begin
                sioc  <= 1'b0;
                qph   <= '0;
                state <= S_BYTE;
              end
            endcase
          end
        end

        // 27 bit slots of 4 quarters each. Data changes only while SIOC is low.
        S_BYTE: begin
          if (tick) begin
            qph <= (qph[1:0] == 2'd3) ? 8'd0 : qph + 8'd1;
            case (qph[1:0])
              2'd0: begin
                if (bit_i == 4'd8) begin
                  siod_oe <= 1'b0;
                  siod_o  <= 1'b1;
                end else begin
                  siod_oe <= 1'b1;
                  siod_o  <= cur_byte[bit_sel];
                end
              end
              2'd1: sioc <= 1'b1;
              2'd3: begin
                sioc <= 1'b0;
                if (bit_i == 4'd8) begin
                  bit_i <= '0;
                  if (byte_i == 2'd2) state  <= S_STOP;
                  else                byte_i <= byte_i + 2'd1;
                end else begin
                  bit_i <= bit_i + 4'd1;
                end
              end
              default: ;
            endcase
          end
        end

        // Stop condition: SIOD rises while SIOC is high, then release the bus.
        S_STOP: begin
          if (tick) begin
            qph <= qph + 8'd1;
            case (qph[1:0])
              2'd0: begin
                siod_oe <= 1'b1;
                siod_o  <= 1'b0;
              end
              2'd1: sioc   <= 1'b1;
              2'd2: siod_o <= 1'b1;
              default: begin
                siod_oe <= 1'b0;
                qph     <= '0;
                if (wr_count != WR_MAX) wr_count <= wr_count + WR_ONE;
                state   <= S_GAP;
              end
            endcase
          end
        end

        S_GAP: begin
          if (tick) begin
            if (qph == GAP_LAST) begin
              qph <= '0;
              // The table does not wrap: the last entry ends the sequence.
              if (tbl_addr == LAST_ADDR) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                tbl_addr <= tbl_addr + ADDR_ONE;
                state    <= S_FETCH;
              end
            end else begin
              qph <= qph + 8'd1;
            end
          end
        end

`ifdef SCCB_DELAY_CMD_EN
        S_DELAY: begin
          if (dly_cnt == 32'd0) begin
            if (tbl_addr == LAST_ADDR) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              tbl_addr <= tbl_addr + ADDR_ONE;
              state    <= S_FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt - 32'd1;
          end
        end
`endif

        // busy/done were already updated on entry to this state.
        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
`timescale 1ns/1ps
module tb_sccb_cfg_sequencer;

  localparam int CLK_HZ = 1_600_000;  // gives QDIV = 4

  // clock / reset
  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESET = 1'b1;
  logic start  = 1'b0;
  logic start2 = 1'b0;

  // dut1: TBL_AW = 8
  logic        busy1, done1, sioc1, siod_o1, siod_oe1;
  logic [8:0]  wr_count1;
  logic [7:0]  tbl_addr1;
  logic [15:0] tbl_data1;
  logic [3:0]  state1;
  // dut2: TBL_AW = 2
  logic        busy2, done2, sioc2, siod_o2, siod_oe2;
  logic [2:0]  wr_count2;
  logic [1:0]  tbl_addr2;
  logic [15:0] tbl_data2;
  logic [3:0]  state2;

  sccb_cfg_sequencer #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start),
    .busy(busy1), .done(done1), .wr_count(wr_count1),
    .tbl_addr(tbl_addr1), .tbl_data(tbl_data1),
    .sioc(sioc1), .siod_o(siod_o1), .siod_oe(siod_oe1), .state_dbg(state1)
  );

  sccb_cfg_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .TBL_AW(2)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .start(start2),
    .busy(busy2), .done(done2), .wr_count(wr_count2),
    .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
    .sioc(sioc2), .siod_o(siod_o2), .siod_oe(siod_oe2), .state_dbg(state2)
  );

  // synchronous ROM models, 1-cycle latency
  logic [15:0] rom1 [0:255];
  logic [15:0] rom2 [0:3];
  always @(posedge ACLK) begin
    tbl_data1 <= rom1[tbl_addr1];
    tbl_data2 <= rom2[tbl_addr2];
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  // SCCB monitor: decodes start, bits on SIOC rise, stop
  logic mon_sel = 1'b0;
  wire  m_sioc = mon_sel ? sioc2 : sioc1;
  wire  m_line = mon_sel ? (siod_oe2 ? siod_o2 : 1'b1) : (siod_oe1 ? siod_o1 : 1'b1);
  logic prev_sioc = 1'b1;
  logic prev_line = 1'b1;
  logic in_txn = 1'b0;
  int   nbits = 0;
  logic [27:0] sh = '0;
  logic [23:0] got, want;

  always @(negedge ACLK) begin
    if (ARESET) begin
      in_txn = 1'b0;
    end else if (prev_sioc && m_sioc && prev_line && !m_line) begin
      in_txn = 1'b1;
      nbits  = 0;
      sh     = '0;
    end else if (in_txn && !prev_sioc && m_sioc) begin
      sh    = {sh[26:0], m_line};
      nbits = nbits + 1;
    end else if (in_txn && prev_sioc && m_sioc && !prev_line && m_line) begin
      in_txn = 1'b0;
      // 27 bit slots plus the SIOC rise inside the stop condition
      got = {sh[27:20], sh[18:11], sh[9:2]};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sccb_txn unexpected: got id/reg/data %h, required no transaction", got);
      end else begin
        want = exp_q.pop_front();
        if (nbits !== 28 || got !== want) begin
          errors++;
          $display("FAIL sccb_txn: got id/reg/data %h (%0d sioc rises), required %h (28)", got, nbits, want);
        end
      end
    end
    prev_sioc = m_sioc;
    prev_line = m_line;
  end

  // driver tasks
  task automatic pulse_start();
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
  endtask

  task automatic pulse_start2();
    @(posedge ACLK); #1 start2 = 1'b1;
    @(posedge ACLK); #1 start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, input string name);
    int n;
    n = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (((which == 1) ? done1 : done2) !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending: %0d transactions outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic load_basic_table();
    rom1[0] = 16'h1280;
    rom1[1] = 16'h1100;
    rom1[2] = 16'hFFFF;
  endtask

  // tests
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({busy1, done1, sioc1, siod_o1, siod_oe1} !== 5'b00110) begin
      errors++;
      $display("FAIL reset_bus: busy/done/sioc/siod_o/siod_oe=%b, required 00110",
               {busy1, done1, sioc1, siod_o1, siod_oe1});
    end
    checks++;
    if (wr_count1 !== 9'd0 || tbl_addr1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: wr_count=%0d tbl_addr=%0d, required 0 0", wr_count1, tbl_addr1);
    end
    checks++;
    if (state1 !== 4'd0 || state2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d/%0d, required 0/0", state1, state2);
    end
    @(posedge ACLK); #1 ARESET = 1'b0;
  endtask

  task automatic test_two_writes();
    load_basic_table();
    exp_q.push_back(24'h42_12_80);
    exp_q.push_back(24'h42_11_00);
    pulse_start();
    @(negedge ACLK);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL two_writes_busy: busy=%b, required 1", busy1);
    end
    wait_done(1, 3000, "two_writes");
    checks++;
    if (wr_count1 !== 9'd2 || busy1 !== 1'b0 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL two_writes_status: wr_count=%0d busy=%b done=%b, required 2 0 1",
               wr_count1, busy1, done1);
    end
    check_queue_empty("two_writes");
  endtask

  task automatic test_end_marker();
    logic sioc_low;
    rom1[0] = 16'hFFFF;
    sioc_low = 1'b0;
    pulse_start();
    @(negedge ACLK);
    sioc_low |= ~sioc1;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL end_marker_accept: busy=%b done=%b, required 1 0", busy1, done1);
    end
    @(negedge ACLK);
    sioc_low |= ~sioc1;
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL end_marker_early: done=%b one cycle after accept, required 0", done1);
    end
    @(negedge ACLK);
    sioc_low |= ~sioc1;
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || wr_count1 !== 9'd0) begin
      errors++;
      $display("FAIL end_marker_done: done=%b busy=%b wr_count=%0d, required 1 0 0",
               done1, busy1, wr_count1);
    end
    repeat (20) begin
      @(negedge ACLK);
      sioc_low |= ~sioc1;
    end
    checks++;
    if (sioc_low !== 1'b0) begin
      errors++;
      $display("FAIL end_marker_sioc: sioc went low=%b, required 0", sioc_low);
    end
  endtask

  task automatic test_start_ignored();
    load_basic_table();
    exp_q.push_back(24'h42_12_80);
    exp_q.push_back(24'h42_11_00);
    pulse_start();
    repeat (650) @(negedge ACLK);
    pulse_start();  // second entry is in flight
    repeat (5) @(negedge ACLK);
    checks++;
    if (tbl_addr1 !== 8'd1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_addr: tbl_addr=%0d busy=%b, required 1 1", tbl_addr1, busy1);
    end
    wait_done(1, 3000, "start_ignored");
    checks++;
    if (wr_count1 !== 9'd2 || tbl_addr1 !== 8'd2) begin
      errors++;
      $display("FAIL start_ignored_end: wr_count=%0d tbl_addr=%0d, required 2 2", wr_count1, tbl_addr1);
    end
    check_queue_empty("start_ignored");
  endtask

  task automatic test_reset_mid();
    load_basic_table();
    pulse_start();
    repeat (200) @(negedge ACLK);  // inside the reg_addr byte
    checks++;
    if (state1 !== 4'd4) begin
      errors++;
      $display("FAIL reset_mid_pos: state=%0d before reset, required 4", state1);
    end
    @(posedge ACLK); #1 ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({sioc1, siod_oe1, busy1, done1} !== 4'b1000 || wr_count1 !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_bus: sioc/siod_oe/busy/done=%b wr_count=%0d, required 1000 0",
               {sioc1, siod_oe1, busy1, done1}, wr_count1);
    end
    @(posedge ACLK); #1 ARESET = 1'b0;
    exp_q.push_back(24'h42_12_80);
    exp_q.push_back(24'h42_11_00);
    pulse_start();
    wait_done(1, 3000, "reset_mid_rerun");
    checks++;
    if (wr_count1 !== 9'd2) begin
      errors++;
      $display("FAIL reset_mid_rerun: wr_count=%0d, required 2", wr_count1);
    end
    check_queue_empty("reset_mid");
  endtask

  task automatic test_delay_cmd();
    logic [8:0] exp_wr;
    rom1[0] = 16'hF002;
    rom1[1] = 16'h1100;
    rom1[2] = 16'hFFFF;
`ifdef SCCB_DELAY_CMD_EN
    exp_wr = 9'd1;
    exp_q.push_back(24'h42_11_00);
    pulse_start();
    begin
      logic idle_bad;
      idle_bad = 1'b0;
      repeat (3200) begin
        @(negedge ACLK);
        if (sioc1 !== 1'b1 || siod_oe1 !== 1'b0 || busy1 !== 1'b1) idle_bad = 1'b1;
      end
      checks++;
      if (idle_bad) begin
        errors++;
        $display("FAIL delay_idle: bus activity or busy drop=%b during 3200 cycles, required 0", idle_bad);
      end
    end
`else
    exp_wr = 9'd2;
    exp_q.push_back(24'h42_F0_02);
    exp_q.push_back(24'h42_11_00);
    pulse_start();
`endif
    wait_done(1, 6000, "delay_cmd");
    checks++;
    if (wr_count1 !== exp_wr) begin
      errors++;
      $display("FAIL delay_cmd_count: wr_count=%0d, required %0d", wr_count1, exp_wr);
    end
    check_queue_empty("delay_cmd");
  endtask

  task automatic test_no_marker();
    logic addr_bad;
    rom2[0] = 16'h0101;
    rom2[1] = 16'h0202;
    rom2[2] = 16'h0303;
    rom2[3] = 16'h0404;
    mon_sel = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back({8'h42, 8'(i), 8'(i)});
    pulse_start2();
    wait_done(2, 4000, "no_marker");
    checks++;
    if (wr_count2 !== 3'd4 || tbl_addr2 !== 2'd3 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL no_marker_status: wr_count=%0d tbl_addr=%0d busy=%b, required 4 3 0",
               wr_count2, tbl_addr2, busy2);
    end
    addr_bad = 1'b0;
    repeat (10) begin
      @(negedge ACLK);
      if (tbl_addr2 !== 2'd3 || state2 !== 4'd0) addr_bad = 1'b1;
    end
    checks++;
    if (addr_bad) begin
      errors++;
      $display("FAIL no_marker_wrap: tbl_addr=%0d state=%0d, required 3 0", tbl_addr2, state2);
    end
    check_queue_empty("no_marker");
    mon_sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom1[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++)   rom2[i] = 16'hFFFF;
    test_reset();
    test_two_writes();
    test_end_marker();
    test_start_ignored();
    test_reset_mid();
    test_delay_cmd();
    test_no_marker();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
